// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle core: opcode/funct values, FSM states, ALU ops.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_LUI
  } alu_op_e;

endpackage

// File: rtl/mc_alu.sv
// Combinational ALU; shifts act on b (the rt operand), lui places b[15:0] in bits 31:16.
module mc_alu
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  input  alu_op_e         alu_op,
  output logic [XLEN-1:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result[0] = $signed(a) < $signed(b);
      ALU_SLL: result = b << shamt;
      ALU_SRL: result = b >> shamt;
      ALU_LUI: result[31:16] = b[15:0];
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mc_cpu_core.sv
// Multi-cycle MIPS-subset core sharing one word-addressed memory port for fetch and data.
module mc_cpu_core
  import cpu_pkg::*;
#(
  parameter int                XLEN     = 32,
  parameter int                NREGS    = 32,
  parameter int                ADDR_W   = 12,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ready,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              halted,
  output logic [ADDR_W-1:0] pc_out
);

  localparam int RW = $clog2(NREGS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [31:0]       ir_q, ir_d;
  logic [XLEN-1:0]   a_q, a_d, b_q, b_d, imm_q, imm_d, res_q, res_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic [XLEN-1:0]   rf_q [NREGS];
  logic              rf_we;
  logic [RW-1:0]     rf_waddr;
  logic [XLEN-1:0]   rf_wdata;

  logic [5:0]        op, funct;
  logic [4:0]        shamt;
  logic [RW-1:0]     rs_idx, rt_idx, rd_idx;
  logic              illegal, taken, go_fetch;
  alu_op_e           alu_op;
  logic [XLEN-1:0]   alu_b, alu_res;

  assign op     = ir_q[31:26];
  assign funct  = ir_q[5:0];
  assign shamt  = ir_q[10:6];
  assign rs_idx = ir_q[21 +: RW];
  assign rt_idx = ir_q[16 +: RW];
  assign rd_idx = ir_q[11 +: RW];

  always_comb begin
    alu_op  = ALU_ADD;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW: alu_op = ALU_ADD;
      OP_ANDI:               alu_op = ALU_AND;
      OP_ORI:                alu_op = ALU_OR;
      OP_LUI:                alu_op = ALU_LUI;
      OP_BEQ, OP_BNE, OP_J:  alu_op = ALU_SUB;
      default:               illegal = 1'b1;
    endcase
  end

  assign alu_b = (op == OP_RTYPE) ? b_q : imm_q;
  assign taken = ((op == OP_BEQ) && (a_q == b_q)) || ((op == OP_BNE) && (a_q != b_q));

  mc_alu #(.XLEN(XLEN)) u_alu (
    .a      (a_q),
    .b      (alu_b),
    .shamt  (shamt),
    .alu_op (alu_op),
    .result (alu_res)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    b_d      = b_q;
    imm_d    = imm_q;
    res_d    = res_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rf_we    = 1'b0;
    rf_waddr = (op == OP_RTYPE) ? rd_idx : rt_idx;
    rf_wdata = res_q;
    go_fetch = 1'b0;

    case (state_q)
      FETCH: begin
        if (req_q && mem_ready) begin
          ir_d    = mem_rdata[31:0];
          ipc_d   = pc_q;
          req_d   = 1'b0;
          state_d = DECODE;
        end else if (!req_q) begin
          // first cycle out of reset: raise the fetch request
          req_d  = 1'b1;
          we_d   = 1'b0;
          addr_d = pc_q;
        end
      end
      DECODE: begin
        a_d     = rf_q[rs_idx];
        b_d     = rf_q[rt_idx];
        imm_d   = ((op == OP_ANDI) || (op == OP_ORI)) ? {{(XLEN-16){1'b0}}, ir_q[15:0]}
                                                      : {{(XLEN-16){ir_q[15]}}, ir_q[15:0]};
        state_d = EXEC;
      end
      EXEC: begin
        if (illegal) begin
          state_d = HALT;
        end else begin
          res_d = alu_res;
          pc_d  = pc_q + ADDR_W'(1);
          case (op)
            OP_BEQ, OP_BNE: begin
              if (taken) pc_d = pc_q + ADDR_W'(1) + imm_q[ADDR_W-1:0];
              go_fetch = 1'b1;
            end
            OP_J: begin
              pc_d     = ir_q[ADDR_W-1:0];
              go_fetch = 1'b1;
            end
            OP_LW, OP_SW: begin
              state_d = MEM;
              req_d   = 1'b1;
              we_d    = (op == OP_SW);
              addr_d  = a_q[ADDR_W-1:0] + imm_q[ADDR_W-1:0];
              wdata_d = b_q;
            end
            default: state_d = WB;
          endcase
        end
      end
      MEM: begin
        if (mem_ready) begin
          if (we_q) begin
            go_fetch = 1'b1;
          end else begin
            res_d   = mem_rdata;
            req_d   = 1'b0;
            state_d = WB;
          end
        end
      end
      WB: begin
        rf_we    = (rf_waddr != '0);
        go_fetch = 1'b1;
      end
      HALT: req_d = 1'b0;
      default: state_d = HALT;
    endcase

    // request outputs are registered, so the fetch is launched on the same edge as the state change
    if (go_fetch) begin
      state_d = FETCH;
      req_d   = 1'b1;
      we_d    = 1'b0;
      addr_d  = pc_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ipc_q   <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      imm_q   <= '0;
      res_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      imm_q   <= imm_d;
      res_q   <= res_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (rf_we) begin
      rf_q[rf_waddr] <= rf_wdata;
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign halted    = (state_q == HALT);
  assign pc_out    = (state_q == FETCH) ? pc_q : ipc_q;

endmodule

// File: tb/tb_mc_cpu_core.sv
// Scoreboard bench: expected memory transactions (with start-to-start cycle gaps) are queued
// by the stimulus and checked by a monitor whenever the core completes a memory handshake.
module tb_mc_cpu_core;

  logic        clk, rst;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [11:0] mem_addr, pc_out;
  logic [31:0] mem_wdata, mem_rdata;

  mc_cpu_core #(.XLEN(32), .NREGS(32), .ADDR_W(12), .RESET_PC(12'h000)) dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .halted(halted), .pc_out(pc_out)
  );

  typedef struct {
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    int          gap;   // cycles since previous request started; -1 = unchecked
  } exp_t;

  exp_t        q[$];
  logic [31:0] tbmem [4096];
  int          checks = 0, errors = 0;
  int          wr_wait = 0;

  assign mem_rdata = tbmem[mem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input logic we, input logic [11:0] addr, input logic [31:0] wd, input int gap);
    exp_t e;
    e.we = we; e.addr = addr; e.wdata = wd; e.gap = gap;
    q.push_back(e);
  endtask

  task automatic f(input logic [11:0] addr, input int gap);
    push(1'b0, addr, 32'h0, gap);
  endtask

  task automatic drain(input int maxc, input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < maxc) begin
      @(negedge clk); #2;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d transactions still pending after %0d cycles", tag, q.size(), maxc);
      q.delete();
    end
  endtask

  task automatic reset_on;
    @(negedge clk); #2;
    rst = 1'b1;
  endtask

  task automatic reset_off;
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  // memory responder: reads zero-wait, writes delayed by wr_wait cycles; ready idles high
  int rcnt;
  initial begin
    mem_ready = 1'b1;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (rst || !mem_req) begin
        mem_ready = 1'b1;
        rcnt = 0;
      end else begin
        if (mem_ready) rcnt = 0;
        if (rcnt >= (mem_we ? wr_wait : 0)) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          rcnt++;
        end
      end
    end
  end

  // monitor
  int          cyc = 0, last_start = 0, gap = 0;
  logic        pend = 1'b0, hs = 1'b0, hs_prev = 1'b0;
  logic        s_we;
  logic [11:0] s_addr;
  logic [31:0] s_wd;
  exp_t        e;
  initial begin
    forever begin
      @(negedge clk); #1;
      cyc++;
      if (rst) begin
        pend = 1'b0;
        hs_prev = 1'b0;
      end else begin
        if (mem_req && (!pend || hs_prev)) begin
          gap = cyc - last_start;
          last_start = cyc;
          s_we = mem_we; s_addr = mem_addr; s_wd = mem_wdata;
          pend = 1'b1;
        end else if (mem_req) begin
          chk("hold_we", {31'b0, mem_we}, {31'b0, s_we});
          chk("hold_addr", {20'b0, mem_addr}, {20'b0, s_addr});
          chk("hold_wdata", mem_wdata, s_wd);
        end
        if (!mem_req) pend = 1'b0;
        hs = mem_req && mem_ready;
        if (hs) begin
          if (mem_we) tbmem[mem_addr] = mem_wdata;
          if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_txn: got we=%0b addr=0x%03h, none expected", mem_we, mem_addr);
          end else begin
            e = q.pop_front();
            chk("txn_we", {31'b0, mem_we}, {31'b0, e.we});
            chk("txn_addr", {20'b0, mem_addr}, {20'b0, e.addr});
            if (e.we) chk("txn_wdata", mem_wdata, e.wdata);
            if (e.gap >= 0) chk("txn_gap", gap, e.gap);
          end
        end
        hs_prev = hs;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int n;
  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4096; i++) tbmem[i] = 32'h0;

    // program A: arithmetic, slow stores, load-back, branch/jump, PC wrap
    tbmem[0]  = 32'h3C010001; // lui  r1,1
    tbmem[1]  = 32'h34210005; // ori  r1,r1,5
    tbmem[2]  = 32'h2002FFFD; // addi r2,r0,-3
    tbmem[3]  = 32'h00221820; // add  r3,r1,r2
    tbmem[4]  = 32'hAC030004; // sw   r3,4(r0)
    tbmem[5]  = 32'h8C040004; // lw   r4,4(r0)
    tbmem[6]  = 32'hAC040102; // sw   r4,0x102(r0)
    tbmem[7]  = 32'h20000007; // addi r0,r0,7
    tbmem[8]  = 32'h00002820; // add  r5,r0,r0
    tbmem[9]  = 32'h0041302A; // slt  r6,r2,r1
    tbmem[10] = 32'hAC050100; // sw   r5,0x100(r0)
    tbmem[11] = 32'hAC060101; // sw   r6,0x101(r0)
    tbmem[12] = 32'h14000007; // bne  r0,r0,+7
    tbmem[13] = 32'h08001FFF; // j    0x1FFF
    tbmem[12'hFFF] = 32'h00013900; // sll r7,r1,4
    wr_wait = 3;
    f(0, -1); f(1, 4); f(2, 4); f(3, 4); f(4, 4);
    push(1'b1, 12'h004, 32'h00010002, 3);
    f(5, 4);
    push(1'b0, 12'h004, 32'h0, 3);
    f(6, 2);
    push(1'b1, 12'h102, 32'h00010002, 3);
    f(7, 4); f(8, 4); f(9, 4); f(10, 4);
    push(1'b1, 12'h100, 32'h00000000, 3);
    f(11, 4);
    push(1'b1, 12'h101, 32'h00000001, 3);
    f(12, 4); f(13, 3); f(12'hFFF, 3); f(0, 4);

    #12;
    chk("rst_mem_req", {31'b0, mem_req}, 0);
    chk("rst_mem_we", {31'b0, mem_we}, 0);
    chk("rst_mem_addr", {20'b0, mem_addr}, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_halted", {31'b0, halted}, 0);
    chk("rst_pc_out", {20'b0, pc_out}, 0);
    reset_off();
    drain(300, "drain_A");

    // program B: srl/andi/sub/sll/or with zero-wait stores, then an illegal opcode at PC 9
    reset_on();
    tbmem[0] = 32'h2001FFF0; // addi r1,r0,-16
    tbmem[1] = 32'h00011102; // srl  r2,r1,4
    tbmem[2] = 32'h3023FF35; // andi r3,r1,0xFF35
    tbmem[3] = 32'h00412022; // sub  r4,r2,r1
    tbmem[4] = 32'h00012900; // sll  r5,r1,4
    tbmem[5] = 32'h00653025; // or   r6,r3,r5
    tbmem[6] = 32'hAC040200; // sw   r4,0x200(r0)
    tbmem[7] = 32'hAC030201; // sw   r3,0x201(r0)
    tbmem[8] = 32'hAC060202; // sw   r6,0x202(r0)
    tbmem[9] = 32'hFC000000; // opcode 0x3F
    wr_wait = 0;
    f(0, -1); f(1, 4); f(2, 4); f(3, 4); f(4, 4); f(5, 4); f(6, 4);
    push(1'b1, 12'h200, 32'h1000000F, 3);
    f(7, 1);
    push(1'b1, 12'h201, 32'h0000FF30, 3);
    f(8, 1);
    push(1'b1, 12'h202, 32'hFFFFFF30, 3);
    f(9, 1);
    reset_off();
    drain(300, "drain_B");
    n = 0;
    while (!halted && n < 6) begin
      @(negedge clk); #2;
      n++;
    end
    chk("halted", {31'b0, halted}, 1);
    chk("halt_within_3", {31'b0, (n <= 3)}, 1);
    chk("halt_pc_out", {20'b0, pc_out}, 12'h009);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #2;
      chk("halt_mem_req", {31'b0, mem_req}, 0);
    end

    // program C: beq to itself at PC 5
    reset_on();
    tbmem[0] = 32'h08000005; // j   5
    tbmem[5] = 32'h1000FFFF; // beq r0,r0,-1
    f(0, -1); f(5, 3); f(5, 3); f(5, 3);
    reset_off();
    drain(100, "drain_C");

    // program D: reset while a store is stuck waiting for ready
    reset_on();
    tbmem[0] = 32'h20010055; // addi r1,r0,0x55
    tbmem[1] = 32'hAC010300; // sw   r1,0x300(r0)
    wr_wait = 100000;
    f(0, -1); f(1, 4);
    reset_off();
    drain(100, "drain_D");
    n = 0;
    while (!(mem_req && mem_we) && n < 10) begin
      @(negedge clk); #2;
      n++;
    end
    chk("stuck_sw_req", {31'b0, mem_req && mem_we}, 1);
    chk("stuck_sw_addr", {20'b0, mem_addr}, 12'h300);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_mem_req", {31'b0, mem_req}, 0);
    chk("arst_mem_we", {31'b0, mem_we}, 0);
    chk("arst_mem_addr", {20'b0, mem_addr}, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_halted", {31'b0, halted}, 0);
    chk("arst_pc_out", {20'b0, pc_out}, 0);
    chk("arst_mem_untouched", tbmem[12'h300], 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cpu_core.md
Name: mc_cpu_core

Overview:
Parametrised multi-cycle successor to the single-cycle core. It executes the same MIPS-style 32-bit encoding subset, adds addi/bne/slt/shifts and PC-relative branches, and traps on illegal opcodes. Instructions and data go through one word-addressed memory port with a req/ready handshake, so wait-state RAM is tolerated. It sits between the top level and the shared RAM model and replaces internal fetch/decode/ALU instances.

Parameters:
XLEN, 32, datapath/register width; must be >= 32; immediates sign- or zero-extended to XLEN.
NREGS, 32, architectural register count; power of two, 2..32; register index = low log2(NREGS) bits of the 5-bit field.
ADDR_W, 12, word-address width of memory port and PC.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
mem_req  out  1  memory request; held until accepted
mem_we  out  1  1 = write (sw), 0 = read (fetch or lw)
mem_addr  out  ADDR_W  word address
mem_wdata  out  XLEN  store data
mem_ready  in  1  request accepted and completed this cycle
mem_rdata  in  XLEN  read data, valid when mem_ready=1 and mem_we=0; instruction = bits [31:0]
halted  out  1  core is in HALT
pc_out  out  ADDR_W  PC of the instruction in flight

Behaviour:
- Reset (async assert): state=FETCH, PC=RESET_PC, all registers=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0. An in-flight memory request is abandoned and no write-back occurs.
- FSM: FETCH -> DECODE -> EXEC -> {MEM | WB | FETCH} ; MEM -> {WB (lw) | FETCH (sw)} ; WB -> FETCH ; any illegal opcode -> HALT (sticky until rst).
- FETCH: mem_req=1, mem_we=0, mem_addr=PC. On edge with mem_ready=1: latch IR and go to DECODE. Otherwise hold all outputs stable.
- DECODE: read rs and rt into A and B. Form imm as sign-extended imm16, or zero-extended for andi/ori.
- EXEC: ALU operates on A and B/imm. All PC updates happen here.
  - R-type (op 0x00) funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed), 0x00 sll, 0x02 srl (by shamt). Any other funct is illegal -> HALT.
  - I-type: 0x08 addi, 0x0C andi, 0x0D ori, 0x0F lui (rt = imm16<<16, zero-extended to XLEN), 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne.
  - J-type: 0x02 j, PC = addr26[ADDR_W-1:0].
  - Branch taken: PC = PC+1+sext(imm16), truncated to ADDR_W (wraps). Not taken: PC = PC+1. Branches and j return to FETCH.
  - All other instructions: PC = PC+1, wrapping modulo 2^ADDR_W.
  - Effective address for lw/sw = (rs + sext(imm16))[ADDR_W-1:0].
- MEM: mem_req=1. For sw, mem_we=1 and mem_wdata=B, then FETCH on ready. For lw, mem_we=0; latch rdata on ready, then WB.
- WB: write result to rd (R-type) or rt (I-type). Writes to register 0 are discarded, and register 0 always reads 0.
- Latency with zero-wait memory (mem_ready tied 1): ALU op 4 cycles, lw 5, sw 4, branch/j 3. Each wait cycle adds exactly 1.
- mem_ready while mem_req=0 is ignored.
- HALT: mem_req=0, halted=1, pc_out frozen at the faulting instruction's PC.

Decomposition:
- Package cpu_pkg: opcode and funct localparams, state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), ALU-op enum.
- Sub-module mc_alu: combinational; inputs a, b, shamt, alu_op; output result (XLEN). It replaces the old clocked ALU.
- Register file is inline.

Test Plan:
- lui r1,0x0001; ori r1,r1,0x0005; addi r2,r0,-3; add r3,r1,r2 -> r3 = 0x00010002. With mem_ready tied 1, the add completes 4 cycles after its fetch request.
- sw r3,4(r0) with mem_ready delayed 3 cycles, then lw r4,4(r0) -> mem_addr/mem_wdata/mem_we held stable across the wait cycles; r4 = 0x00010002.
- beq r0,r0,-1 at PC=5 -> next fetch at 5. bne r0,r0,+7 -> next fetch at PC+1. j 0x1FFF with ADDR_W=12 -> PC = 0xFFF, and the next sequential fetch wraps to 0.
- addi r0,r0,7, then add r5,r0,r0 -> r5 = 0. slt r6,r2,r1 (-3 < 0x10005) -> r6 = 1.
- Opcode 0x3F at PC=9 -> halted=1 and pc_out=9 within 3 cycles, mem_req=0 thereafter. rst pulse -> fetch restarts at RESET_PC.
- Assert rst while mem_req=1 in MEM for an sw with mem_ready=0 -> mem_req drops with no clock edge, memory unchanged, all outputs at reset values.
